// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic buffer placed between two pipeline stages.
// It is a small circular FIFO with DEPTH entries and valid/ready handshakes on both sides.
// Both handshake outputs come only from state: ready_o is derived from the occupancy
// register, and data_o is read from the storage array.
// flush_i discards all contents. It takes priority over any push or pop in the same cycle.
// Optional feature: define PIPE_PERF_CNT_EN to build the saturating stall and flush
// counters. When it is undefined, both counter outputs are tied to 0.

module pipe_stage_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_i,
    input  logic [DATA_WIDTH-1:0]        data_i,
    output logic                         ready_o,
    output logic                         valid_o,
    output logic [DATA_WIDTH-1:0]        data_o,
    input  logic                         ready_i,
    input  logic                         flush_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic [CNT_WIDTH-1:0]         stall_cnt_o,
    output logic [CNT_WIDTH-1:0]         flush_cnt_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    localparam logic [OCC_W-1:0] FULL_LEVEL = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0]      rdPtr;
    logic [PTR_W-1:0]      wrPtr;
    logic [OCC_W-1:0]      occupancy;
    logic                  doPush;
    logic                  doPop;
    logic [PTR_W-1:0]      rdPtrNext;
    logic [PTR_W-1:0]      wrPtrNext;

    // The handshake outputs depend only on the occupancy register.
    // A pop therefore never opens the input side within the same cycle.
    assign ready_o = (occupancy < FULL_LEVEL);
    assign valid_o = (occupancy != '0);
    assign count_o = occupancy;

    // Present the oldest word; the output is forced to zero while the buffer is empty.
    always_comb begin
        data_o = '0;
        if (valid_o) begin
            data_o = storage[rdPtr];
        end
    end

    // Decode this cycle's transfers; a flush suppresses both of them.
    always_comb begin
        doPush = valid_i && ready_o && !flush_i;
        doPop  = valid_o && ready_i && !flush_i;
    end

    // Each pointer advance wraps from the last index back to entry 0.
    always_comb begin
        rdPtrNext = (rdPtr == LAST_IDX) ? '0 : rdPtr + PTR_W'(1);
        wrPtrNext = (wrPtr == LAST_IDX) ? '0 : wrPtr + PTR_W'(1);
    end

    // Write the payload into storage; the storage array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (doPush) begin
            storage[wrPtr] <= data_i;
        end
    end

    // Maintain the pointers and occupancy; a flush returns everything to entry 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            occupancy <= '0;
        end else if (flush_i) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            occupancy <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtrNext;
            end
            if (doPop) begin
                rdPtr <= rdPtrNext;
            end
            case ({doPush, doPop})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stallCount;
    logic [CNT_WIDTH-1:0] flushCount;

    // Count the stalled and flushed cycles; each counter saturates at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            if (valid_o && !ready_i && !flush_i && (stallCount != '1)) begin
                stallCount <= stallCount + CNT_WIDTH'(1);
            end
            if (flush_i && (flushCount != '1)) begin
                flushCount <= flushCount + CNT_WIDTH'(1);
            end
        end
    end

    assign stall_cnt_o = stallCount;
    assign flush_cnt_o = flushCount;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: width of each payload word.
REQ-002 The block SHALL have parameter DEPTH, default 2, legal values 1..8: number of buffer entries.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 32: width of the performance counters.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port valid_i, input, 1 bit: upstream stage offers data_i.
REQ-007 The block SHALL have port data_i, input, DATA_WIDTH bits: upstream payload (PC, instruction or result).
REQ-008 The block SHALL have port ready_o, output, 1 bit: the buffer accepts a word this cycle.
REQ-009 The block SHALL have port valid_o, output, 1 bit: data_o holds a valid word.
REQ-010 The block SHALL have port data_o, output, DATA_WIDTH bits: oldest buffered payload.
REQ-011 The block SHALL have port ready_i, input, 1 bit: downstream stage consumes data_o this cycle.
REQ-012 The block SHALL have port flush_i, input, 1 bit: discard all contents (taken branch or jump).
REQ-013 The block SHALL have port count_o, output, $clog2(DEPTH+1) bits: current occupancy.
REQ-014 The block SHALL have ports stall_cnt_o and flush_cnt_o, outputs, CNT_WIDTH bits each: performance counters (see REQ-029).

Function
REQ-015 A push SHALL occur when valid_i && ready_o && !flush_i.
REQ-016 A pop SHALL occur when valid_o && ready_i && !flush_i.
REQ-017 Storage SHALL be a circular buffer with read and write pointers wrapping from DEPTH-1 to 0; count_o SHALL equal the number of stored words.
REQ-018 ready_o SHALL be driven from registers only: high iff count_o < DEPTH; it SHALL have no combinational path from ready_i.
REQ-019 valid_o SHALL be high iff count_o > 0; data_o SHALL be the entry at the read pointer, driven from registers (no path from data_i).
REQ-020 Latency SHALL be one cycle: a word pushed in cycle N is presented on data_o in cycle N+1 at the earliest.
REQ-021 On simultaneous push and pop, count_o SHALL be unchanged and both pointers SHALL advance; sustained throughput SHALL be one word per cycle for DEPTH >= 2.
REQ-022 When full (count_o == DEPTH), ready_o is low and valid_i SHALL be ignored, even if a pop occurs in the same cycle.
REQ-023 When empty, ready_i SHALL be ignored and count_o SHALL NOT underflow.
REQ-024 data_o SHALL remain stable while valid_o && !ready_i (stall); ordering SHALL be strictly FIFO.
REQ-025 flush_i SHALL take priority over push and pop: next cycle count_o = 0, valid_o = 0, both pointers = 0; a word offered in the flush cycle SHALL be dropped.
REQ-026 Flush on an empty buffer SHALL be legal and leave the buffer empty.

Reset
REQ-027 Asserting rst low SHALL immediately clear count_o, pointers, valid_o and both counters to 0, and set ready_o to 1, including in the middle of an operation.
REQ-028 Storage contents need not be reset; data_o SHALL read 0 while valid_o is 0.

Configuration
REQ-029 With macro PIPE_PERF_CNT_EN defined: stall_cnt_o increments on each cycle with valid_o && !ready_i && !flush_i; flush_cnt_o increments on each cycle with flush_i high; both saturate at all-ones.
REQ-030 Without PIPE_PERF_CNT_EN: stall_cnt_o and flush_cnt_o SHALL be constant 0 and no counter registers are synthesised.

Verification
REQ-031 Reset: rst low mid-stream with count_o = 2 -> same cycle count_o = 0, valid_o = 0, ready_o = 1, data_o = 0.
REQ-032 Fill: DEPTH=2, push 0xA, 0xB with ready_i = 0 -> count_o = 2, ready_o = 0; a third push of 0xC is dropped; releasing ready_i yields 0xA then 0xB.
REQ-033 Streaming: DEPTH=2, push 0x1..0x8 on consecutive cycles with ready_i = 1 -> outputs 0x1..0x8 on consecutive cycles, one cycle later, count_o = 1 in steady state.
REQ-034 Flush: count_o = 2 with push 0x5 and pop in the same cycle as flush_i = 1 -> next cycle count_o = 0, 0x5 is never output.
REQ-035 Wrap: DEPTH=3, 10 push/pop pairs with random stalls -> output order matches input order across pointer wrap.
REQ-036 Counters (PIPE_PERF_CNT_EN): 4 stall cycles and 2 flush cycles -> stall_cnt_o = 4, flush_cnt_o = 2; without the macro -> both 0.
